tot_fine_encoder_pipe: RTL and testbench

Pipelined, parametrised successor of the ETROC2 TOT fine-phase encoder. It converts an N_TAPS-bit ring-delay-line snapshot into a binary fine code. The snapshot must be an odd-length, single-edge thermometer code. Bubble tolerance is selectable at run time, and the block counts encoding errors. It sits between the TOT sample DFFs and the TDC data formatter, with a valid flag qualifying every sample.

---
 rtl/tot_enc_pkg.sv | 19 +
 rtl/tot_bubble_filter.sv | 29 ++
 rtl/tot_fine_encoder_pipe.sv | 148 ++++++++++++++
 tb/tb_tot_fine_encoder_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tot_enc_pkg.sv
// Shared constants and helpers for the TOT fine-phase encoder pipeline.
package tot_enc_pkg;

  localparam int TOT_N_TAPS_DEFAULT = 21;
  localparam int MAX_LEVEL          = 3;
  localparam int LEVEL_W            = $clog2(MAX_LEVEL + 1);

  function automatic int pos_width(input int n_taps);
    return $clog2(n_taps);
  endfunction

  // Shortest distance between two taps going either way round the ring.
  function automatic int ring_dist(input int a, input int b, input int n_taps);
    int d;
    d = (a > b) ? a - b : b - a;
    return (d < n_taps - d) ? d : n_taps - d;
  endfunction

endpackage

// File: rtl/tot_bubble_filter.sv
// Bubble filter: keeps an adjacency bit only if no other adjacency bit lies
// within ring distance 1..L-1 of it, where L = max(level, 1).
module tot_bubble_filter
  import tot_enc_pkg::*;
#(
  parameter int N_TAPS = TOT_N_TAPS_DEFAULT
) (
  input  logic [N_TAPS-1:0]  adj,
  input  logic [LEVEL_W-1:0] level,
  output logic [N_TAPS-1:0]  filt
);

  logic [LEVEL_W-1:0] tol;

  assign tol = (level == '0) ? LEVEL_W'(1) : level;

  always_comb begin
    // NOTE: give every always_comb output a default first so no path can infer a latch.
    filt = adj;
    for (int i = 0; i < N_TAPS; i++) begin
      for (int k = 0; k < N_TAPS; k++) begin
        if (k != i && adj[k] && ring_dist(i, k, N_TAPS) < int'(tol)) begin
          filt[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/tot_fine_encoder_pipe.sv
// Three-stage TOT fine-phase encoder: capture, adjacency + bubble filter, encode.
// Define FINE_ENC_ERR_CNT_EN to build the saturating err_cnt counter and err_clr.
module tot_fine_encoder_pipe
  import tot_enc_pkg::*;
#(
  parameter  int N_TAPS    = TOT_N_TAPS_DEFAULT,
  parameter  int ERR_CNT_W = 8,
  localparam int POS_W     = pos_width(N_TAPS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [N_TAPS-1:0]    encode_In,
  input  logic [LEVEL_W-1:0]   level,
  input  logic                 err_clr,
  output logic                 out_valid,
  output logic [POS_W:0]       Binary_Out,
  output logic                 errorFlag,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [N_TAPS-1:0]  r_q, r_d;
  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic               v1_q, v1_d;
  logic [N_TAPS-1:0]  f_q, f_d;
  logic               msb_q, msb_d;
  logic               v2_q, v2_d;
  logic [POS_W:0]     bin_q, bin_d;
  logic               err_q, err_d;
  logic               v3_q, v3_d;

  logic [N_TAPS-1:0]  adj;
  logic [N_TAPS-1:0]  filt;
  logic [POS_W-1:0]   pos;
  logic               enc_err;

  // adj[i] is set where tap i equals its ring predecessor (tap 0 wraps to tap N_TAPS-1).
  assign adj = ~(r_q ^ {r_q[N_TAPS-2:0], r_q[N_TAPS-1]});

  tot_bubble_filter #(.N_TAPS(N_TAPS)) u_filter (
    .adj   (adj),
    .level (lvl_q),
    .filt  (filt)
  );

  // Lowest set index wins; anything other than exactly one set bit is an error.
  always_comb begin : s3_encode
    logic found;
    found   = 1'b0;
    pos     = '0;
    enc_err = 1'b1;
    for (int i = 0; i < N_TAPS; i++) begin
      if (f_q[i]) begin
        if (!found) begin
          pos     = POS_W'(i);
          enc_err = 1'b0;
          found   = 1'b1;
        end else begin
          enc_err = 1'b1;
        end
      end
    end
  end

  always_comb begin : next_state
    r_d   = r_q;
    lvl_d = lvl_q;
    v1_d  = in_valid;
    f_d   = f_q;
    msb_d = msb_q;
    v2_d  = v1_q;
    bin_d = bin_q;
    err_d = err_q;
    v3_d  = v2_q;
    if (in_valid) begin
      r_d   = encode_In;
      lvl_d = level;
    end
    if (v1_q) begin
      f_d   = filt;
      msb_d = ~r_q[N_TAPS-1];
    end
    if (v2_q) begin
      bin_d = {msb_q, pos};
      err_d = enc_err;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: data registers are cleared as well, so outputs read 0 after reset rather than stale samples.
    if (!rstn) begin
      r_q   <= '0;
      lvl_q <= '0;
      v1_q  <= 1'b0;
      f_q   <= '0;
      msb_q <= 1'b0;
      v2_q  <= 1'b0;
      bin_q <= '0;
      err_q <= 1'b0;
      v3_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous value of the stage before it.
      r_q   <= r_d;
      lvl_q <= lvl_d;
      v1_q  <= v1_d;
      f_q   <= f_d;
      msb_q <= msb_d;
      v2_q  <= v2_d;
      bin_q <= bin_d;
      err_q <= err_d;
      v3_q  <= v3_d;
    end
  end

  assign out_valid  = v3_q;
  assign Binary_Out = bin_q;
  assign errorFlag  = err_q;

`ifdef FINE_ENC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts during the cycle a flagged result is presented; clear beats increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (v3_q && err_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_tot_fine_encoder_pipe.sv
// Self-checking bench for tot_fine_encoder_pipe (N_TAPS=21): table vectors,
// reset flush, counter saturation/clear and randomized traffic against a model.
module tb_tot_fine_encoder_pipe;

  localparam int N       = 21;
  localparam int PW      = 5;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [N-1:0]  encode_In;
  logic [1:0]    level;
  logic          err_clr;
  logic          out_valid;
  logic [PW:0]   Binary_Out;
  logic          errorFlag;
  logic [CW-1:0] err_cnt;

  tot_fine_encoder_pipe #(.N_TAPS(N), .ERR_CNT_W(CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .encode_In  (encode_In),
    .level      (level),
    .err_clr    (err_clr),
    .out_valid  (out_valid),
    .Binary_Out (Binary_Out),
    .errorFlag  (errorFlag),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [PW:0] bo;
    logic        err;
  } res_t;

  typedef struct {
    logic [N-1:0] enc;
    logic [1:0]   lvl;
    logic [PW:0]  bo;
    logic         err;
  } vec_t;

  res_t m_s1, m_s2, m_out;
  int   m_cnt;
  int   n_checks;
  int   n_errors;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rdist(input int a, input int b);
    int d;
    d = (a > b) ? a - b : b - a;
    return (d < N - d) ? d : N - d;
  endfunction

  // Reference: list the ring positions where neighbours agree, drop any that
  // have another such position closer than the tolerance, then pick the result.
  function automatic res_t ref_encode(input logic [N-1:0] r, input int lvl);
    int   edges[$];
    int   keep[$];
    int   tol;
    res_t res;
    logic [PW-1:0] p;
    tol = (lvl == 0) ? 1 : lvl;
    for (int i = 0; i < N; i++) begin
      if (r[i] == r[(i + N - 1) % N]) edges.push_back(i);
    end
    foreach (edges[a]) begin
      bit lone;
      lone = 1'b1;
      foreach (edges[b]) begin
        if (a != b && rdist(edges[a], edges[b]) < tol) lone = 1'b0;
      end
      if (lone) keep.push_back(edges[a]);
    end
    p = '0;
    if (keep.size() > 0) p = PW'(keep[0]);
    res.valid = 1'b1;
    res.err   = (keep.size() != 1);
    res.bo    = {~r[N-1], p};
    return res;
  endfunction

  function automatic logic [N-1:0] clean_code(input int p, input logic b);
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[(p + j) % N] = b ^ ((j % 2) == 1);
    return r;
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    res_t inres;
    inres = in_valid ? ref_encode(encode_In, int'(level)) : '0;
    @(posedge clk);
    if (!rstn) begin
      m_s1  = '0;
      m_s2  = '0;
      m_out = '0;
      m_cnt = 0;
    end else begin
`ifdef FINE_ENC_ERR_CNT_EN
      if (err_clr) m_cnt = 0;
      else if (m_out.valid && m_out.err && m_cnt < CNT_MAX) m_cnt++;
`endif
      m_out.valid = m_s2.valid;
      if (m_s2.valid) begin
        m_out.bo  = m_s2.bo;
        m_out.err = m_s2.err;
      end
      m_s2 = m_s1;
      m_s1 = inres;
    end
    #1;
    check("out_valid",  32'(out_valid),  32'(m_out.valid));
    check("Binary_Out", 32'(Binary_Out), 32'(m_out.bo));
    check("errorFlag",  32'(errorFlag),  32'(m_out.err));
    check("err_cnt",    32'(err_cnt),    32'(m_cnt));
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic [1:0] l, input logic c);
    in_valid  = v;
    encode_In = d;
    level     = l;
    err_clr   = c;
    step();
  endtask

  initial begin
    logic [N-1:0] code;
    int           post_rst_valids;

    n_checks  = 0;
    n_errors  = 0;
    m_s1      = '0;
    m_s2      = '0;
    m_out     = '0;
    m_cnt     = 0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    encode_In = '0;
    level     = 2'd1;
    err_clr   = 1'b0;

    vecs[0]  = '{21'h0AAAAA, 2'd1, 6'h20, 1'b0};
    vecs[1]  = '{21'h15552A, 2'd1, 6'h07, 1'b0};
    vecs[2]  = '{21'h0A8AAA, 2'd1, 6'h20, 1'b1};
    vecs[3]  = '{21'h0A8AAA, 2'd2, 6'h20, 1'b0};
    vecs[4]  = '{21'h0A8AAA, 2'd0, 6'h20, 1'b1};
    vecs[5]  = '{21'h0A8AAA, 2'd3, 6'h20, 1'b0};
    vecs[6]  = '{21'h000000, 2'd2, 6'h20, 1'b1};
    vecs[7]  = '{21'h1FFFFF, 2'd1, 6'h00, 1'b1};
    vecs[8]  = '{21'h15552A, 2'd3, 6'h07, 1'b0};
    vecs[9]  = '{21'h05552A, 2'd2, 6'h27, 1'b0};
    vecs[10] = '{21'h05552A, 2'd1, 6'h20, 1'b1};

    step();
    step();
    rstn = 1'b1;

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].enc, vecs[i].lvl, 1'b0);
      drive(1'b0, '0, 2'd1, 1'b0);
      drive(1'b0, '0, 2'd1, 1'b0);
      check($sformatf("tbl%0d_valid", i), 32'(out_valid),  32'd1);
      check($sformatf("tbl%0d_bo", i),    32'(Binary_Out), 32'(vecs[i].bo));
      check($sformatf("tbl%0d_err", i),   32'(errorFlag),  32'(vecs[i].err));
      drive(1'b0, '0, 2'd1, 1'b0);
      check($sformatf("tbl%0d_hold_valid", i), 32'(out_valid),  32'd0);
      check($sformatf("tbl%0d_hold_bo", i),    32'(Binary_Out), 32'(vecs[i].bo));
    end

    // Back-to-back clean codes with a reset in the middle of the stream.
    post_rst_valids = 0;
    for (int k = 0; k < 10; k++) begin
      rstn = (k != 5);
      drive(1'b1, (k % 2 == 1) ? 21'h15552A : 21'h0AAAAA, 2'd1, 1'b0);
      if (k == 5) begin
        check("rst_valid",   32'(out_valid),  32'd0);
        check("rst_bo",      32'(Binary_Out), 32'd0);
        check("rst_err_cnt", 32'(err_cnt),    32'd0);
      end
      if (k > 5 && out_valid) post_rst_valids++;
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 2'd1, 1'b0);
      if (out_valid) post_rst_valids++;
    end
    check("post_rst_valid_count", 32'(post_rst_valids), 32'd4);

    for (int k = 0; k < 400; k++) begin
      code = clean_code($urandom_range(0, N - 1), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) code[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) code[$urandom_range(0, N - 1)] ^= 1'b1;
      drive($urandom_range(0, 3) != 0, code, 2'($urandom_range(0, 3)),
            $urandom_range(0, 31) == 0);
    end

    for (int k = 0; k < 300; k++) drive(1'b1, 21'h0A8AAA, 2'd1, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, '0, 2'd1, 1'b0);
`ifdef FINE_ENC_ERR_CNT_EN
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
`else
    check("err_cnt_sat", 32'(err_cnt), 32'd0);
`endif

    drive(1'b1, 21'h0A8AAA, 2'd1, 1'b0);
    drive(1'b0, '0, 2'd1, 1'b0);
    drive(1'b0, '0, 2'd1, 1'b0);
    check("clr_err_present", 32'({out_valid, errorFlag}), 32'd3);
    drive(1'b0, '0, 2'd1, 1'b1);
    check("err_cnt_clr", 32'(err_cnt), 32'd0);
    drive(1'b0, '0, 2'd1, 1'b0);
    check("err_cnt_after_clr", 32'(err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
